// File: rtl/stage_pkg.sv
// Shared constants and state encoding for the gimbal pitch tracking stage.
// Angles are fixed-point nano-radians (9 fraction digits).
package stage_pkg;

  localparam int unsigned N = 64;

  localparam logic [63:0] NRAD_PER_RAD      = 64'd1_000_000_000;
  localparam logic [63:0] PITCH_MAX_DEFAULT = 64'd1_570_796_327;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARM   = 3'd1,
    S_TRACK = 3'd2,
    S_LIMIT = 3'd3,
    S_HOLD  = 3'd4
  } state_e;

endpackage

// File: rtl/sat_accumulator.sv
// N-bit accumulator with clear, enable and an upper saturation limit.
// hit_o flags that the pending sum (carry included) reaches the limit.
module sat_accumulator #(
  parameter int unsigned N = 64
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [N-1:0] inc_i,
  input  logic [N-1:0] limit_i,
  output logic [N-1:0] acc_o,
  output logic         hit_o
);

  logic [N-1:0] acc_q, acc_d;
  logic [N:0]   sum;

  assign sum   = {1'b0, acc_q} + {1'b0, inc_i};
  assign hit_o = sum[N] | (sum[N-1:0] >= limit_i);

  always_comb begin
    acc_d = acc_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (en_i) begin
      acc_d = hit_o ? limit_i : sum[N-1:0];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/gimbal_pitch_tracker.sv
// Pitch angle integrator for vacuum-phase gimbal steering with saturation.
// Define GIMBAL_RATE_LIMIT_EN to clamp each increment to RATE_MAX.
module gimbal_pitch_tracker
  import stage_pkg::*;
#(
  parameter int unsigned  N         = stage_pkg::N,
  parameter logic [N-1:0] PITCH_MAX = N'(PITCH_MAX_DEFAULT),
  parameter logic [N-1:0] RATE_MAX  = N'(1000)
) (
  input  logic         clk,
  input  logic         resetb,
  input  logic         gimbalEnable,
  input  logic [N-1:0] angularVelocity,
  output logic [N-1:0] pitch,
  output logic         pitchValid,
  output logic         pitchSaturated,
  output logic [N-1:0] trackTicks,
  output logic [2:0]   state
);

  state_e       state_q, state_d;
  logic         en_q;
  logic [N-1:0] ticks_q, ticks_d;
  logic [N-1:0] inc;
  logic [N-1:0] acc;
  logic         start;
  logic         acc_clr, acc_en, acc_hit;
  logic         unused_cfg;

  assign start      = gimbalEnable & ~en_q;
  assign unused_cfg = ^{RATE_MAX, NRAD_PER_RAD};

`ifdef GIMBAL_RATE_LIMIT_EN
  assign inc = (angularVelocity > RATE_MAX) ? RATE_MAX : angularVelocity;
`else
  assign inc = angularVelocity;
`endif

  sat_accumulator #(.N(N)) u_pitch_acc (
    .clk_i   (clk),
    .rst_i   (resetb),
    .clr_i   (acc_clr),
    .en_i    (acc_en),
    .inc_i   (inc),
    .limit_i (PITCH_MAX),
    .acc_o   (acc),
    .hit_o   (acc_hit)
  );

  // Pitch/ticks are cleared on the edge that enters ARM so ARM shows zero;
  // the ARM cycle then integrates like a TRACK cycle when enable is held.
  always_comb begin
    state_d = state_q;
    ticks_d = ticks_q;
    acc_clr = 1'b0;
    acc_en  = 1'b0;
    unique case (state_q)
      S_IDLE, S_HOLD: begin
        if (start) begin
          state_d = S_ARM;
          ticks_d = '0;
          acc_clr = 1'b1;
        end
      end
      S_ARM, S_TRACK: begin
        if (!gimbalEnable) begin
          state_d = (state_q == S_ARM) ? S_IDLE : S_HOLD;
        end else begin
          acc_en  = 1'b1;
          ticks_d = (ticks_q == '1) ? ticks_q : ticks_q + N'(1);
          state_d = acc_hit ? S_LIMIT : S_TRACK;
        end
      end
      S_LIMIT: begin
        if (!gimbalEnable) begin
          state_d = S_HOLD;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (resetb) begin
      state_q <= S_IDLE;
      en_q    <= 1'b0;
      ticks_q <= '0;
    end else begin
      state_q <= state_d;
      en_q    <= gimbalEnable;
      ticks_q <= ticks_d;
    end
  end

  assign pitch          = acc;
  assign trackTicks     = ticks_q;
  assign pitchSaturated = (acc == PITCH_MAX);
  assign pitchValid     = (state_q == S_TRACK) || (state_q == S_LIMIT) || (state_q == S_HOLD);
  assign state          = state_q;

endmodule

// File: tb/tb_gimbal_pitch_tracker.sv
// Directed vector table plus randomized run against a behavioural pitch model.
module tb_gimbal_pitch_tracker;

  localparam int unsigned N    = 64;
  localparam logic [63:0] PMAX = 64'd1570796327;
  localparam logic [63:0] RMAX = 64'd1000;

  logic          clk = 1'b0;
  logic          resetb;
  logic          gimbalEnable;
  logic [N-1:0]  angularVelocity;
  logic [N-1:0]  pitch;
  logic          pitchValid;
  logic          pitchSaturated;
  logic [N-1:0]  trackTicks;
  logic [2:0]    state;

  always #5 clk = ~clk;

  gimbal_pitch_tracker #(
    .N         (N),
    .PITCH_MAX (PMAX),
    .RATE_MAX  (RMAX)
  ) dut (
    .clk             (clk),
    .resetb          (resetb),
    .gimbalEnable    (gimbalEnable),
    .angularVelocity (angularVelocity),
    .pitch           (pitch),
    .pitchValid      (pitchValid),
    .pitchSaturated  (pitchSaturated),
    .trackTicks      (trackTicks),
    .state           (state)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: 0 idle, 1 arm, 2 track, 3 limit, 4 hold
  int          m_state = 0;
  logic [64:0] m_pitch = '0;
  logic [63:0] m_ticks = '0;
  bit          m_prev  = 1'b0;

  function automatic void model_edge(bit rst, bit en, logic [63:0] vel);
    logic [64:0] inc;
    logic [64:0] s;
    bit          start;
    if (rst) begin
      m_state = 0;
      m_pitch = '0;
      m_ticks = '0;
      m_prev  = 1'b0;
      return;
    end
    start = en && !m_prev;
    inc   = {1'b0, vel};
`ifdef GIMBAL_RATE_LIMIT_EN
    if (inc > {1'b0, RMAX}) inc = {1'b0, RMAX};
`endif
    if (m_state == 0 || m_state == 4) begin
      if (start) begin
        m_state = 1;
        m_pitch = '0;
        m_ticks = '0;
      end
    end else if (m_state == 1 || m_state == 2) begin
      if (!en) begin
        m_state = (m_state == 1) ? 0 : 4;
      end else begin
        if (m_ticks != 64'hFFFF_FFFF_FFFF_FFFF) m_ticks = m_ticks + 64'd1;
        s = m_pitch + inc;
        if (s >= {1'b0, PMAX}) begin
          m_pitch = {1'b0, PMAX};
          m_state = 3;
        end else begin
          m_pitch = s;
          m_state = 2;
        end
      end
    end else if (m_state == 3) begin
      if (!en) m_state = 4;
    end
    m_prev = en;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic step(bit rst, bit en, logic [63:0] vel);
    resetb          = rst;
    gimbalEnable    = en;
    angularVelocity = vel;
    @(posedge clk);
    model_edge(rst, en, vel);
    #1;
  endtask

  typedef struct {
    bit          rst;
    bit          en;
    logic [63:0] vel;
    int          cycles;
    logic [2:0]  st;
    logic [63:0] p;
    logic [63:0] t;
    bit          v;
    bit          s;
  } vec_t;

  vec_t vecs[$];

  task automatic add(bit rst, bit en, logic [63:0] vel, int cyc,
                     logic [2:0] st, logic [63:0] p, logic [63:0] t, bit v, bit s);
    vec_t x;
    x.rst = rst; x.en = en; x.vel = vel; x.cycles = cyc;
    x.st = st; x.p = p; x.t = t; x.v = v; x.s = s;
    vecs.push_back(x);
  endtask

  initial begin
    bit          en_r;
    logic [63:0] vel_r;
    int          sel;

    resetb          = 1'b1;
    gimbalEnable    = 1'b0;
    angularVelocity = '0;

    // rst en vel cycles | state pitch ticks valid sat
    add(1, 0, 0,    2,  0, 0,    0,  0, 0);
    add(0, 1, 500,  1,  1, 0,    0,  0, 0);
    add(0, 1, 500,  10, 2, 5000, 10, 1, 0);
    add(0, 0, 500,  1,  4, 5000, 10, 1, 0);
    add(0, 0, 0,    2,  4, 5000, 10, 1, 0);
    add(0, 1, 100,  1,  1, 0,    0,  0, 0);
    add(0, 1, 100,  4,  2, 400,  4,  1, 0);
    add(0, 0, 100,  1,  4, 400,  4,  1, 0);
    add(0, 1, 100,  1,  1, 0,    0,  0, 0);
    add(0, 1, 100,  1,  2, 100,  1,  1, 0);
    add(0, 1, 1000, 3,  2, 3100, 4,  1, 0);
    add(1, 1, 1000, 1,  0, 0,    0,  0, 0);
    add(1, 1, 7,    1,  0, 0,    0,  0, 0);
    add(0, 1, 7,    1,  1, 0,    0,  0, 0);
    add(0, 1, 7,    1,  2, 7,    1,  1, 0);
    add(0, 1, 0,    2,  2, 7,    3,  1, 0);
    add(1, 0, 0,    1,  0, 0,    0,  0, 0);
    add(0, 1, 5000, 1,  1, 0,    0,  0, 0);
`ifdef GIMBAL_RATE_LIMIT_EN
    add(0, 1, 5000, 3,  2, 3000, 3,  1, 0);
`else
    add(0, 1, 5000, 3,  2, 15000, 3, 1, 0);
    add(1, 0, 0,         1, 0, 0,         0, 0, 0);
    add(0, 1, 785398164, 1, 1, 0,         0, 0, 0);
    add(0, 1, 785398164, 1, 2, 785398164, 1, 1, 0);
    add(0, 1, 785398164, 1, 3, PMAX,      2, 1, 1);
    add(0, 1, 5,         2, 3, PMAX,      2, 1, 1);
    add(0, 0, 5,         1, 4, PMAX,      2, 1, 1);
    add(1, 0, 0,          1, 0, 0,          0, 0, 0);
    add(0, 1, 1570796320, 1, 1, 0,          0, 0, 0);
    add(0, 1, 1570796320, 1, 2, 1570796320, 1, 1, 0);
    add(0, 0, 100,        1, 4, 1570796320, 1, 1, 0);
    add(1, 0, 0,                     1, 0, 0,    0, 0, 0);
    add(0, 1, 64'hFFFF_FFFF_FFFF_FFFF, 1, 1, 0,  0, 0, 0);
    add(0, 1, 64'hFFFF_FFFF_FFFF_FFFF, 1, 3, PMAX, 1, 1, 1);
    add(1, 0, 0,    1, 0, 0,    0, 0, 0);
    add(0, 1, 1,    1, 1, 0,    0, 0, 0);
    add(0, 1, PMAX, 1, 3, PMAX, 1, 1, 1);
`endif
    add(1, 0, 0, 2, 0, 0, 0, 0, 0);

    foreach (vecs[i]) begin
      for (int c = 0; c < vecs[i].cycles; c++) step(vecs[i].rst, vecs[i].en, vecs[i].vel);
      chk($sformatf("v%0d_state", i), 64'(state),          64'(vecs[i].st));
      chk($sformatf("v%0d_pitch", i), pitch,                vecs[i].p);
      chk($sformatf("v%0d_ticks", i), trackTicks,           vecs[i].t);
      chk($sformatf("v%0d_valid", i), 64'(pitchValid),     64'(vecs[i].v));
      chk($sformatf("v%0d_sat", i),   64'(pitchSaturated), 64'(vecs[i].s));
    end

    en_r = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 7) == 0) en_r = !en_r;
      sel = int'($urandom_range(0, 9));
      if (sel <= 5)      vel_r = 64'($urandom_range(0, 3000));
      else if (sel <= 7) vel_r = '0;
      else if (sel == 8) vel_r = 64'($urandom_range(0, 900_000_000));
      else               vel_r = {$urandom, $urandom};
      step($urandom_range(0, 99) == 0, en_r, vel_r);
      chk("rnd_state", 64'(state),          64'(m_state));
      chk("rnd_pitch", pitch,                m_pitch[63:0]);
      chk("rnd_ticks", trackTicks,           m_ticks);
      chk("rnd_valid", 64'(pitchValid),     64'(m_state == 2 || m_state == 3 || m_state == 4));
      chk("rnd_sat",   64'(pitchSaturated), 64'(m_pitch[63:0] == PMAX));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gimbal_pitch_tracker.md
GIMBAL_PITCH_TRACKER -- requirements
Module: gimbal_pitch_tracker

Interface
REQ-001 Parameter N, default 64, datapath width in bits.
REQ-002 Parameter PITCH_MAX, default 1570796327, pitch limit in nano-radians (pi/2, 9 fraction digits).
REQ-003 Parameter RATE_MAX, default 1000, largest allowed per-cycle pitch increment in nano-radians.
REQ-004 Port clk input 1: the single clock.
REQ-005 Port resetb input 1: reset, synchronous and active-high.
REQ-006 Port gimbalEnable input 1: level request from the gimbal stage; 1 = vacuum-phase steering active.
REQ-007 Port angularVelocity input N: per-cycle pitch increment in nano-radians, unsigned.
REQ-008 Port pitch output N: accumulated pitch angle in nano-radians.
REQ-009 Port pitchValid output 1: 1 while pitch is tracking or held after a completed track.
REQ-010 Port pitchSaturated output 1: 1 when pitch equals PITCH_MAX.
REQ-011 Port trackTicks output N: number of cycles spent in TRACK since the last start.
REQ-012 Port state output 3: current state encoding, for observability.

Function
REQ-013 States SHALL be IDLE=0, ARM=1, TRACK=2, LIMIT=3 and HOLD=4; other codes are unreachable.
REQ-014 Start is the rising edge of gimbalEnable, detected synchronously against a registered copy; no edge-triggered logic is clocked from gimbalEnable.
REQ-015 IDLE: on start -> ARM; pitch=0, trackTicks=0, pitchValid=0.
REQ-016 ARM: lasts exactly one cycle; clears pitch and trackTicks; -> TRACK if gimbalEnable=1, else -> IDLE.
REQ-017 TRACK: each cycle, pitch <= min(pitch + inc, PITCH_MAX) and trackTicks <= trackTicks+1; inc = angularVelocity sampled that cycle.
REQ-018 The first increment appears on pitch 2 cycles after the cycle in which gimbalEnable is first seen high.
REQ-019 The pitch sum SHALL be computed at N+1 bits; a carry out or a result >= PITCH_MAX forces pitch=PITCH_MAX and -> LIMIT.
REQ-020 LIMIT: pitch is frozen at PITCH_MAX and pitchSaturated=1; trackTicks is frozen; -> HOLD when gimbalEnable=0.
REQ-021 TRACK with gimbalEnable=0 -> HOLD; the increment sampled in that cycle is discarded.
REQ-022 HOLD: pitch and trackTicks are frozen and pitchValid=1; on a new start -> ARM (re-arms from zero).
REQ-023 pitchValid=1 in TRACK, LIMIT and HOLD; 0 in IDLE and ARM.
REQ-024 trackTicks saturates at all-ones and does not wrap.
REQ-025 angularVelocity=0 in TRACK is legal: pitch holds and trackTicks still increments.
REQ-026 If the saturation condition and gimbalEnable=0 occur in the same cycle, the -> HOLD transition takes precedence and pitch keeps its prior value.

Reset
REQ-027 While resetb=1 at a clk edge: state=IDLE, pitch=0, trackTicks=0, pitchValid=0, pitchSaturated=0, registered gimbalEnable copy=0.
REQ-028 Reset asserted in any state, including mid-TRACK, SHALL abort to IDLE.
REQ-029 After reset deasserts with gimbalEnable already high, that level counts as a start (copy=0), so the block -> ARM on the next cycle.

Configuration
REQ-030 Macro GIMBAL_RATE_LIMIT_EN defined: inc = min(angularVelocity, RATE_MAX).
REQ-031 Macro GIMBAL_RATE_LIMIT_EN undefined: inc = angularVelocity unmodified, and RATE_MAX is ignored.

Structure
REQ-032 The shared package stage_pkg SHALL hold N, the 1e9 fixed-point scale constant, the PITCH_MAX default and the state encoding.
REQ-033 The one sub-module is sat_accumulator: an N-bit accumulator with clear, enable and saturation limit, instantiated for pitch.

Verification
REQ-034 Reset, then gimbalEnable=1 with angularVelocity=500 for 10 TRACK cycles -> pitch=5000, trackTicks=10, pitchValid=1.
REQ-035 angularVelocity=PITCH_MAX/2+1 for 2 TRACK cycles -> pitch=1570796327, pitchSaturated=1, state=LIMIT.
REQ-036 Drop gimbalEnable after 4 cycles at 100, then raise it again -> pitch=400 in HOLD; re-arm gives pitch=0 in ARM and 100 one cycle later.
REQ-037 resetb=1 mid-TRACK with pitch=3000 -> next cycle state=IDLE, pitch=0 and all flags 0.
REQ-038 With GIMBAL_RATE_LIMIT_EN, angularVelocity=5000 for 3 cycles -> pitch=3000; without it -> pitch=15000.
REQ-039 Saturation and gimbalEnable=0 in the same cycle -> state=HOLD, pitch unchanged, pitchSaturated=0.
